// File: rtl/spi_in_frame.sv
// spi_in_frame: framed SPI-slave receiver with selectable sample edge and bit order.
// Delivers each frame through a valid/ready holding register and flags short/long frames and overruns.
module spi_in_frame #(
  parameter int DATA_WIDTH  = 2,
  parameter int DATA_DEPTH  = 16,
  parameter int SYNC_DEPTH  = 2,
  parameter int SAMPLE_EDGE = 0,
  parameter int MSB_FIRST   = 1,
  localparam int N  = DATA_WIDTH * DATA_DEPTH,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_clk,
  input  logic          spi_en,
  input  logic          spi_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [N-1:0]  data_out,
  output logic [CW-1:0] bit_count,
  output logic          frame_err,
  output logic          overrun
);
  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_END} state_t;
  state_t r_state;
  logic [SYNC_DEPTH-1:0] r_clk_sync, r_en_sync, r_dat_sync;
  logic r_clk_d, r_en_d, r_extra;
  logic [N-1:0] r_shift;
  logic w_clk_s, w_en_s, w_dat_s, w_samp, w_en_rise, w_en_fall;
  logic [N-1:0] w_shift_nxt;
  assign w_clk_s     = r_clk_sync[SYNC_DEPTH-1];
  assign w_en_s      = r_en_sync[SYNC_DEPTH-1];
  assign w_dat_s     = r_dat_sync[SYNC_DEPTH-1];
  assign w_samp      = (SAMPLE_EDGE != 0) ? (r_clk_d & ~w_clk_s) : (~r_clk_d & w_clk_s);
  assign w_en_rise   = ~r_en_d & w_en_s;
  assign w_en_fall   = r_en_d & ~w_en_s;
  assign w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[N-2:0], w_dat_s} : {w_dat_s, r_shift[N-1:1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= '0;
      r_en_sync  <= '0;
      r_dat_sync <= '0;
      r_clk_d    <= 1'b0;
      r_en_d     <= 1'b0;
      r_extra    <= 1'b0;
      r_shift    <= '0;
      r_state    <= IDLE;
      out_valid  <= 1'b0;
      data_out   <= '0;
      bit_count  <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_DEPTH-2:0], spi_clk};
      r_en_sync  <= {r_en_sync[SYNC_DEPTH-2:0], spi_en};
      r_dat_sync <= {r_dat_sync[SYNC_DEPTH-2:0], spi_data};
      r_clk_d    <= w_clk_s;
      r_en_d     <= w_en_s;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_en_rise) begin
          r_shift   <= '0;
          bit_count <= '0;
          r_extra   <= 1'b0;
          r_state   <= ACTIVE;
        end
        ACTIVE: if (w_en_fall) begin
          frame_err <= 1'b1;
          bit_count <= '0;
          r_state   <= IDLE;
        end else if (w_samp) begin
          r_shift   <= w_shift_nxt;
          bit_count <= bit_count + 1'b1;
          if (bit_count == CW'(N - 1)) begin
            r_state <= WAIT_END;
            // a frame may load in the same cycle the previous one is accepted
            if (!out_valid || out_ready) begin
              data_out  <= w_shift_nxt;
              out_valid <= 1'b1;
            end else overrun <= 1'b1;
          end
        end
        WAIT_END: if (w_en_fall) begin
          bit_count <= '0;
          r_state   <= IDLE;
        end else if (w_samp && !r_extra) begin
          frame_err <= 1'b1;
          r_extra   <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_in_frame.sv
// tb_spi_in_frame: directed bench for spi_in_frame with N = 8.
// Three instances share the SPI pins: default options, LSB-first, and falling-edge sampling.
module tb_spi_in_frame;
  localparam int H = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic spi_clk = 1'b0, spi_en = 1'b0, spi_data = 1'b0, out_ready = 1'b1;
  logic       ov_m, fe_m, or_m, ov_l, fe_l, or_l, ov_f, fe_f, or_f;
  logic [7:0] do_m, do_l, do_f;
  logic [3:0] bc_m, bc_l, bc_f;
  int tests = 0, fails = 0;
  int n_ov = 0, n_fe = 0, n_or = 0;
  int b_ov, b_fe, b_or;

  always #5 clk = ~clk;

  spi_in_frame #(.DATA_WIDTH(2), .DATA_DEPTH(4)) dut_m (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_en(spi_en), .spi_data(spi_data),
    .out_ready(out_ready), .out_valid(ov_m), .data_out(do_m), .bit_count(bc_m),
    .frame_err(fe_m), .overrun(or_m));
  spi_in_frame #(.DATA_WIDTH(2), .DATA_DEPTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_en(spi_en), .spi_data(spi_data),
    .out_ready(out_ready), .out_valid(ov_l), .data_out(do_l), .bit_count(bc_l),
    .frame_err(fe_l), .overrun(or_l));
  spi_in_frame #(.DATA_WIDTH(2), .DATA_DEPTH(4), .SAMPLE_EDGE(1)) dut_f (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_en(spi_en), .spi_data(spi_data),
    .out_ready(out_ready), .out_valid(ov_f), .data_out(do_f), .bit_count(bc_f),
    .frame_err(fe_f), .overrun(or_f));

  always @(negedge clk) begin
    if (ov_m) n_ov++;
    if (fe_m) n_fe++;
    if (or_m) n_or++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_ov = n_ov;
    b_fe = n_fe;
    b_or = n_or;
  endtask

  // bits are sent from bits[n-1] down; rise_chg moves data changes onto the rising spi_clk edge
  task automatic send(input logic [15:0] bits, input int n, input bit rise_chg, input bit drop);
    spi_en = 1'b1;
    wait_clk(H);
    for (int i = 0; i < n; i++) begin
      if (!rise_chg) spi_data = bits[n-1-i];
      wait_clk(H);
      spi_clk = 1'b1;
      if (rise_chg) spi_data = bits[n-1-i];
      wait_clk(H);
      spi_clk = 1'b0;
      wait_clk(H);
    end
    if (drop) begin
      spi_en = 1'b0;
      wait_clk(H + 4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    wait_clk(3);
    chk("reset_valid", ov_m, 0);
    chk("reset_data", do_m, 0);
    chk("reset_count", bc_m, 0);
    rst = 1'b0;
    wait_clk(2);

    snap();
    send(16'hB2, 8, 0, 1);
    chk("nom_data", do_m, 8'hB2);
    chk("nom_valid_cycles", n_ov - b_ov, 1);
    chk("nom_ferr", n_fe - b_fe, 0);
    chk("nom_overrun", n_or - b_or, 0);
    chk("lsb_data", do_l, 8'h4D);
    chk("fall_data", do_f, 8'hB2);

    snap();
    send(16'h16, 5, 0, 1);
    chk("short_ferr", n_fe - b_fe, 1);
    chk("short_valid", n_ov - b_ov, 0);
    chk("short_count", bc_m, 0);
    send(16'hFF, 8, 0, 1);
    chk("after_short_data", do_m, 8'hFF);
    chk("after_short_fall", do_f, 8'hFF);

    send(16'hB2, 8, 1, 1);
    chk("fall_rise_chg_data", do_f, 8'hB2);

    snap();
    send({6'd0, 8'h6C, 2'b11}, 10, 0, 0);
    wait_clk(H);
    chk("long_count_hold", bc_m, 8);
    spi_en = 1'b0;
    wait_clk(H + 4);
    chk("long_data", do_m, 8'h6C);
    chk("long_ferr", n_fe - b_fe, 1);
    chk("long_valid", n_ov - b_ov, 1);
    chk("long_count_clr", bc_m, 0);

    out_ready = 1'b0;
    snap();
    send(16'h11, 8, 0, 1);
    chk("bp_first_valid", ov_m, 1);
    chk("bp_first_data", do_m, 8'h11);
    send(16'h22, 8, 0, 1);
    chk("bp_hold_data", do_m, 8'h11);
    chk("bp_overrun", n_or - b_or, 1);
    chk("bp_still_valid", ov_m, 1);
    out_ready = 1'b1;
    wait_clk(2);
    chk("bp_drained", ov_m, 0);
    send(16'h33, 8, 0, 1);
    chk("bp_new_data", do_m, 8'h33);

    send(16'h0F, 4, 0, 0);
    chk("mid_count", bc_m, 4);
    rst = 1'b1;
    spi_en = 1'b0;
    wait_clk(1);
    chk("rst_valid", ov_m, 0);
    chk("rst_data", do_m, 0);
    chk("rst_count", bc_m, 0);
    chk("rst_ferr", fe_m, 0);
    chk("rst_overrun", or_m, 0);
    wait_clk(H);
    rst = 1'b0;
    wait_clk(2);
    snap();
    send(16'hA5, 8, 0, 1);
    chk("post_rst_data", do_m, 8'hA5);
    chk("post_rst_lsb", do_l, 8'hA5);
    chk("post_rst_ferr", n_fe - b_fe, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_in_frame.md
Name: spi_in_frame

Overview:
- Parametrised, framed SPI-slave input receiver. Second generation of the team's spi_in path.
- Adds selectable sample edge, bit order, a valid/ready output handshake with a one-frame holding register, short/long-frame error detection and overrun reporting.
- Sits between the external SPI pins and the downstream frame consumer. All logic runs in the clk domain.

Parameters:
- DATA_WIDTH, 2, bits per sample.
- DATA_DEPTH, 16, samples per frame. Frame length N = DATA_WIDTH*DATA_DEPTH, N >= 2.
- SYNC_DEPTH, 2, flops per input synchroniser, >= 2.
- SAMPLE_EDGE, 0, 0 = sample on spi_clk rising edge, 1 = sample on falling edge.
- MSB_FIRST, 1, 1 = first received bit lands in data_out[N-1], 0 = first bit lands in data_out[0].

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- spi_clk  input  1  asynchronous SPI clock.
- spi_en  input  1  asynchronous frame enable, active high.
- spi_data  input  1  asynchronous serial data.
- out_ready  input  1  consumer accepts the held frame.
- out_valid  output  1  data_out holds a complete frame.
- data_out  output  N  received frame; stable while out_valid = 1.
- bit_count  output  $clog2(N+1)  bits received in the current frame.
- frame_err  output  1  one-cycle pulse: short or long frame.
- overrun  output  1  one-cycle pulse: completed frame dropped.

Behaviour:
- Reset (async, rst = 1): all synchroniser flops, shift register, data_out, bit_count, out_valid, frame_err, overrun = 0; FSM = IDLE. Asserting rst mid-frame discards the partial frame and any held frame.
- Synchronisers: spi_clk, spi_en and spi_data each pass through SYNC_DEPTH flops.
- Edge detection on the synchronised signals, one extra flop each:
  - samp = synced rising edge of spi_clk (SAMPLE_EDGE = 0) or falling edge (SAMPLE_EDGE = 1).
  - en_rise / en_fall = synced spi_en edges.
- FSM states IDLE, ACTIVE, WAIT_END:
  - IDLE: samp ignored. On en_rise: shift register <= 0, bit_count <= 0, go to ACTIVE. A samp in the same cycle as en_rise is ignored.
  - ACTIVE, samp: shift in the synced data bit toward MSB (MSB_FIRST = 1) or toward LSB (MSB_FIRST = 0); bit_count += 1.
  - ACTIVE, samp with bit_count == N-1: the frame is complete. Go to WAIT_END; bit_count becomes N.
    - If out_valid = 0, or out_valid = 1 and out_ready = 1 in that cycle: data_out <= final frame including the new bit, and out_valid = 1 in the next cycle.
    - Otherwise: frame dropped, data_out unchanged, overrun = 1 for one cycle.
  - ACTIVE, en_fall with bit_count < N (checked before samp; en_fall has priority): frame_err pulse, frame discarded, go to IDLE, bit_count <= 0.
  - WAIT_END, samp: frame_err pulses once (first extra edge only). bit_count saturates at N. Held frame unaffected.
  - WAIT_END, en_fall: go to IDLE, bit_count <= 0.
- Handshake:
  - out_valid rises one clk after the completing samp cycle.
  - out_valid stays high until a cycle with out_valid & out_ready, then falls next cycle unless a new frame loads in that same cycle.
  - data_out changes only on load.
- Latency: pin edge to samp is SYNC_DEPTH+1 clk cycles; final samp to out_valid is 1 cycle.
- spi_clk and spi_en must each be stable for at least SYNC_DEPTH+1 clk periods per level. Faster toggling is not detected and is not required to work.
- bit_count width is $clog2(N+1). No wrap: it holds at N.

Test Plan (DATA_WIDTH = 2, DATA_DEPTH = 4, N = 8; MSB_FIRST = 1, SAMPLE_EDGE = 0 unless stated):
- Nominal frame: en high, 8 rising edges carrying 1,0,1,1,0,0,1,0, en low, out_ready = 1 -> data_out = 8'hB2, out_valid high exactly 1 cycle, no error pulses.
- Options: same bits with MSB_FIRST = 0 -> 8'h4D. With SAMPLE_EDGE = 1 and data changing only on rising edges -> 8'hB2.
- Short frame: en low after 5 edges -> frame_err one pulse, out_valid stays 0, next full frame 8'hFF received correctly.
- Long frame: 10 edges -> frame delivered from the first 8 bits, frame_err exactly one pulse, bit_count holds 8.
- Backpressure: out_ready = 0, send frames 8'h11 then 8'h22 -> data_out stays 8'h11, overrun one pulse. Raise out_ready, send 8'h33 -> 8'h33 delivered.
- Reset mid-frame: rst after 4 edges -> all outputs 0, FSM IDLE; following frame 8'hA5 received correctly.
